// File: rtl/scatter_sequencer.sv
// Timestep controller: feeds particles to the scatterer, waits for the drain, then sweeps the grid
// in address pairs and realigns the returned charges with a tag pipeline before forwarding them to the solver.
package scatter_sequencer_pkg;
  typedef enum logic {STEP_SOLVE = 1'b0, STEP_SCATTER = 1'b1} step_t;
endpackage

module scatter_sequencer
  import scatter_sequencer_pkg::*;
#(
  parameter int PCOUNT_W       = 16,
  parameter int SOLVE_LAT      = 6,
  parameter int GUARD          = 2,
  parameter int DRAIN_TIMEOUT  = 1024,
  parameter int GRID_ADDRWIDTH = 4,
  parameter int CWIDTH         = 8,
  parameter int PWIDTH         = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [PCOUNT_W-1:0]            num_particles,
  output logic                           busy,
  output logic                           done,
  output logic                           err_timeout,
  output step_t                          step,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [PWIDTH-1:0]              s_data,
  output logic                           valid_scatter,
  output logic                           tlast_in,
  output logic [PWIDTH-1:0]              particle_out,
  input  logic                           scat_tlast,
  input  logic                           solve_ready,
  output logic                           valid_req,
  output logic [1:0][GRID_ADDRWIDTH-1:0] grid_addr_out,
  input  logic [1:0][3:0][CWIDTH-1:0]    charge_in,
  output logic                           m_valid,
  output logic [GRID_ADDRWIDTH-2:0]      m_addr,
  output logic [1:0][3:0][CWIDTH-1:0]    m_charge
);
  localparam int KW    = GRID_ADDRWIDTH - 1;
  localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 2 * GUARD) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_FEED, S_DRAIN, S_TURN, S_ISSUE, S_FLUSH, S_FIN
  } state_t;

  state_t                       state_r, state_s;
  logic [CNT_W-1:0]             cnt_r, cnt_s;
  logic [PCOUNT_W-1:0]          pcnt_r, pcnt_s, n_r;
  logic [KW-1:0]                k_r, k_s, req_k_r;
  logic [SOLVE_LAT-1:0]         tag_v_r;
  logic [SOLVE_LAT-1:0][KW-1:0] tag_k_r;
  logic                         xfer_s, last_part_s, accept_s, timeout_s;
  logic                         busy_s, done_s, err_s, s_ready_s, vs_s, tlast_s, vr_s;
  step_t                        step_s;
  logic [1:0][GRID_ADDRWIDTH-1:0] grid_addr_s;

  assign xfer_s      = s_valid & s_ready;
  assign last_part_s = (pcnt_r == n_r - PCOUNT_W'(1));
  assign accept_s    = (state_r == S_IDLE) & start;
  assign timeout_s   = (state_r == S_DRAIN) & ~scat_tlast & (cnt_r == CNT_W'(DRAIN_TIMEOUT - 1));

  // State and sequencing counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      pcnt_r  <= '0;
      k_r     <= '0;
      n_r     <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pcnt_r  <= pcnt_s;
      k_r     <= k_s;
      if (accept_s) n_r <= num_particles;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pcnt_s  = pcnt_r;
    k_s     = k_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          pcnt_s  = '0;
          cnt_s   = '0;
          state_s = (num_particles == '0) ? S_TURN : S_LEAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LEAD: begin
        if (cnt_r == CNT_W'(GUARD - 1)) begin
          cnt_s   = '0;
          state_s = S_FEED;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_FEED: begin
        if (xfer_s) begin
          pcnt_s = pcnt_r + PCOUNT_W'(1);
          if (last_part_s) begin
            cnt_s   = '0;
            state_s = S_DRAIN;
          end else begin
            state_s = S_FEED;
          end
        end else begin
          state_s = S_FEED;
        end
      end
      S_DRAIN: begin
        if (scat_tlast || timeout_s) begin
          cnt_s   = '0;
          state_s = S_TURN;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_TURN: begin
        if (cnt_r == CNT_W'(2 * GUARD - 1)) begin
          cnt_s   = '0;
          state_s = S_ISSUE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (solve_ready) begin
          k_s     = k_r + KW'(1);
          state_s = (k_r == '1) ? S_FLUSH : S_ISSUE;
        end else begin
          state_s = S_ISSUE;
        end
      end
      S_FLUSH: begin
        // Leave only once the last tagged pair has left the return pipeline
        if (!valid_req && (tag_v_r == '0)) begin
          state_s = S_FIN;
        end else begin
          state_s = S_FLUSH;
        end
      end
      S_FIN: begin
        k_s     = '0;
        state_s = S_IDLE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    busy_s    = (state_s != S_IDLE);
    done_s    = (state_s == S_FIN);
    s_ready_s = (state_s == S_FEED) && (pcnt_s < n_r);
    vs_s      = xfer_s;
    tlast_s   = xfer_s & last_part_s;
    vr_s      = (state_r == S_ISSUE) & solve_ready;
    if (state_r == S_LEAD && state_s == S_FEED) begin
      step_s = STEP_SCATTER;
    end else if (state_r == S_TURN && cnt_r == CNT_W'(GUARD - 1)) begin
      step_s = STEP_SOLVE;
    end else begin
      step_s = step;
    end
    if (accept_s) begin
      err_s = 1'b0;
    end else if (timeout_s) begin
      err_s = 1'b1;
    end else begin
      err_s = err_timeout;
    end
    if (vr_s) begin
      grid_addr_s = {{k_r, 1'b1}, {k_r, 1'b0}};
    end else begin
      grid_addr_s = '0;
    end
  end

  // Output registers and the return-path tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      step          <= STEP_SOLVE;
      s_ready       <= 1'b0;
      valid_scatter <= 1'b0;
      tlast_in      <= 1'b0;
      particle_out  <= '0;
      valid_req     <= 1'b0;
      grid_addr_out <= '0;
      req_k_r       <= '0;
      tag_v_r       <= '0;
      tag_k_r       <= '0;
      m_valid       <= 1'b0;
      m_addr        <= '0;
      m_charge      <= '0;
    end else begin
      busy          <= busy_s;
      done          <= done_s;
      err_timeout   <= err_s;
      step          <= step_s;
      s_ready       <= s_ready_s;
      valid_scatter <= vs_s;
      tlast_in      <= tlast_s;
      if (xfer_s) particle_out <= s_data;
      valid_req     <= vr_s;
      grid_addr_out <= grid_addr_s;
      if (vr_s) req_k_r <= k_r;
      tag_v_r       <= {tag_v_r[SOLVE_LAT-2:0], valid_req};
      tag_k_r       <= {tag_k_r[SOLVE_LAT-2:0], req_k_r};
      m_valid       <= tag_v_r[SOLVE_LAT-1];
      if (tag_v_r[SOLVE_LAT-1]) begin
        m_addr   <= tag_k_r[SOLVE_LAT-1];
        m_charge <= charge_in;
      end
    end
  end
endmodule

// File: tb/tb_scatter_sequencer.sv
// Randomized directed bench for scatter_sequencer: a transaction-level model predicts particle order,
// pair sweep order, return timing/charges, guard spacing, timeout timing and done placement.
module tb_scatter_sequencer;
  import scatter_sequencer_pkg::*;

  localparam int PCOUNT_W = 16, SOLVE_LAT = 6, GUARD = 2, DRAIN_TIMEOUT = 1024;
  localparam int GAW = 4, CW = 8, PW = 32;
  localparam int PAIRS = 1 << (GAW - 1);
  typedef logic [1:0][3:0][CW-1:0] charge_t;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [PCOUNT_W-1:0] num_particles = '0;
  logic busy, done, err_timeout, s_ready, valid_scatter, tlast_in, valid_req, m_valid;
  step_t step;
  logic s_valid = 1'b0, scat_tlast = 1'b0, solve_ready = 1'b0;
  logic [PW-1:0] s_data = '0, particle_out;
  logic [1:0][GAW-1:0] grid_addr_out;
  charge_t charge_in = '0, m_charge;
  logic [GAW-2:0] m_addr;

  scatter_sequencer #(
    .PCOUNT_W(PCOUNT_W), .SOLVE_LAT(SOLVE_LAT), .GUARD(GUARD), .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .GRID_ADDRWIDTH(GAW), .CWIDTH(CW), .PWIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_particles(num_particles), .busy(busy),
    .done(done), .err_timeout(err_timeout), .step(step), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .valid_scatter(valid_scatter), .tlast_in(tlast_in), .particle_out(particle_out),
    .scat_tlast(scat_tlast), .solve_ready(solve_ready), .valid_req(valid_req),
    .grid_addr_out(grid_addr_out), .charge_in(charge_in), .m_valid(m_valid), .m_addr(m_addr),
    .m_charge(m_charge)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0, cyc = 0;
  logic [PW-1:0] src_q[$], exp_scat[$];
  int hist_v[$], hist_k[$], exp_t[$], exp_k[$];
  int n_cur, n_vs, next_k, last_m_t, first_vs_t, last_vs_t, tl_cnt, fall_exp, fall_t, first_vr_t;
  int sv_mode, sr_mode, cbase = 0;
  bit withhold, spur, saw_scatter;
  step_t step_prev = STEP_SOLVE;
  bit vs_prev, vr_prev, err_prev;

  function automatic charge_t ramp(int k);
    charge_t r;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 4; i++)
        r[j][i] = CW'(cbase + (2 * k + j) * 4 + i);
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit xfer, prev_sr;
    int v, k, t;
    logic [PW-1:0] e;
    xfer = s_valid && s_ready;
    prev_sr = solve_ready;
    @(posedge clk); #1; cyc++;
    if (xfer && src_q.size() > 0) void'(src_q.pop_front());
    if (step == STEP_SCATTER) saw_scatter = 1'b1;
    if (valid_scatter) begin
      check("vs_step", step, STEP_SCATTER);
      check("vs_in_budget", n_vs < n_cur, 1'b1);
      check("vs_tlast", tlast_in, n_vs == n_cur - 1);
      if (exp_scat.size() > 0) begin
        e = exp_scat.pop_front();
        check("vs_data", particle_out, e);
      end
      if (n_vs == 0) first_vs_t = cyc;
      last_vs_t = cyc;
      n_vs++;
      if (tlast_in && !withhold) tl_cnt = 1 + $urandom_range(0, 6);
    end
    if (valid_req) begin
      check("vr_after_ready", prev_sr, 1'b1);
      check("vr_step", step, STEP_SOLVE);
      check("vr_in_budget", next_k < PAIRS, 1'b1);
      check("vr_addr", grid_addr_out, {GAW'(2 * next_k + 1), GAW'(2 * next_k)});
      if (first_vr_t < 0) first_vr_t = cyc;
      exp_t.push_back(cyc + SOLVE_LAT + 1);
      exp_k.push_back(next_k);
      next_k++;
    end
    hist_v.push_back(int'(valid_req));
    hist_k.push_back(int'(grid_addr_out[0]) / 2);
    if (m_valid) begin
      check("mv_expected", exp_t.size() > 0, 1'b1);
      if (exp_t.size() > 0) begin
        t = exp_t.pop_front();
        k = exp_k.pop_front();
        check("mv_time", cyc, t);
        check("mv_addr", m_addr, k);
        check("mv_charge", m_charge, ramp(k));
      end
      last_m_t = cyc;
    end
    if (done) check("done_after_last_mv", cyc, last_m_t + 1);
    if (step !== step_prev) begin
      check("step_quiet", {valid_scatter, valid_req, vs_prev, vr_prev, exp_t.size() == 0}, 5'b00001);
      if (step == STEP_SOLVE) begin
        check("step_fall_time", cyc, fall_exp);
        fall_t = cyc;
      end
    end
    if (!busy) check("idle_step_solve", step, STEP_SOLVE);
    if (err_timeout && !err_prev) begin
      check("err_after_timeout", cyc - last_vs_t, DRAIN_TIMEOUT);
      fall_exp = cyc + GUARD;
    end
    step_prev = step; vs_prev = valid_scatter; vr_prev = valid_req; err_prev = err_timeout;
    // Drive the inputs seen at the next edge
    scat_tlast = 1'b0;
    if (tl_cnt > 0) begin
      tl_cnt--;
      if (tl_cnt == 0) begin
        scat_tlast = 1'b1;
        fall_exp = cyc + 1 + GUARD;
      end
    end else if (spur) begin
      scat_tlast = ($urandom_range(0, 7) == 0);
    end
    if (src_q.size() > 0) begin
      s_data = src_q[0];
      s_valid = (sv_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end else begin
      s_valid = 1'b0;
      s_data = $urandom;
    end
    case (sr_mode)
      0: solve_ready = 1'b1;
      1: solve_ready = ~solve_ready;
      default: solve_ready = ($urandom_range(0, 1) == 1);
    endcase
    if (hist_v.size() > SOLVE_LAT) begin
      v = hist_v.pop_front();
      k = hist_k.pop_front();
      charge_in = (v != 0) ? ramp(k) : charge_t'({$urandom, $urandom});
    end
  endtask

  task automatic prep(int n, int svm, int srm, bit wh);
    logic [PW-1:0] p;
    src_q.delete(); exp_scat.delete();
    for (int i = 0; i < n; i++) begin
      p = $urandom;
      src_q.push_back(p);
      exp_scat.push_back(p);
    end
    n_cur = n; n_vs = 0; next_k = 0; last_m_t = -100; first_vr_t = -1; fall_t = -1;
    fall_exp = -1; tl_cnt = 0; sv_mode = svm; sr_mode = srm; withhold = wh; saw_scatter = 1'b0;
    cbase = $urandom_range(0, 255);
    start = 1'b1;
    num_particles = PCOUNT_W'(n);
    tick();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_err_clear", err_timeout, 1'b0);
  endtask

  task automatic run_step(int n, int svm, int srm, bit wh, bit poke_issue, bit poke_done);
    bit seen_done, poked;
    int budget;
    prep(n, svm, srm, wh);
    seen_done = 1'b0; poked = 1'b0; budget = 0;
    while (!seen_done && budget < 5000) begin
      tick();
      budget++;
      start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        if (poke_done) begin start = 1'b1; num_particles = PCOUNT_W'(3); end
      end else if (poke_issue && !poked && valid_req) begin
        poked = 1'b1; start = 1'b1; num_particles = PCOUNT_W'(2);
      end
    end
    check("done_seen", seen_done, 1'b1);
    tick();
    start = 1'b0;
    check("post_idle", busy, 1'b0);
    check("vs_total", n_vs, n);
    check("pairs_total", next_k, PAIRS);
    check("mv_pending", exp_t.size(), 0);
    check("err_final", err_timeout, wh);
    check("scatter_seen", saw_scatter, n > 0);
    if (n > 0 && svm == 0) check("vs_consecutive", last_vs_t - first_vs_t, n - 1);
    if (n > 0 && srm == 0) check("guard_before_issue", first_vr_t - fall_t, GUARD + 1);
    repeat (3) begin
      tick();
      check("stay_idle", busy, 1'b0);
    end
  endtask

  initial begin
    int budget;
    #1 rst_n = 1'b0;
    #2;
    check("reset_flags", {busy, done, err_timeout, s_ready, valid_scatter, tlast_in, valid_req, m_valid}, 8'h00);
    check("reset_step", step, STEP_SOLVE);
    check("reset_data", {particle_out, grid_addr_out, m_addr}, '0);
    check("reset_charge", m_charge, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();

    run_step(4, 0, 0, 1'b0, 1'b0, 1'b0);
    spur = 1'b1;
    run_step(0, 1, 2, 1'b0, 1'b0, 1'b0);
    spur = 1'b0;

    // Asynchronous reset in the middle of feeding
    prep(8, 0, 0, 1'b0);
    budget = 0;
    while (n_vs < 3 && budget < 200) begin tick(); budget++; end
    check("rst_reached_3", n_vs, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_step", step, STEP_SOLVE);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    src_q.delete(); exp_scat.delete(); hist_v.delete(); hist_k.delete();
    exp_t.delete(); exp_k.delete(); tl_cnt = 0; n_cur = 0;
    step_prev = step; vs_prev = 1'b0; vr_prev = 1'b0; err_prev = 1'b0; s_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) begin
      tick();
      check("post_rst_mv", m_valid, 1'b0);
      check("post_rst_vs", valid_scatter, 1'b0);
    end

    run_step(5, 1, 2, 1'b1, 1'b0, 1'b0);
    run_step(3, 1, 1, 1'b0, 1'b1, 1'b1);
    for (int r = 0; r < 3; r++)
      run_step($urandom_range(1, 20), $urandom_range(0, 1), $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
